// File: rtl/thee_pll_lock_det.sv
// rtl/thee_pll_lock_det.sv - PLL lock detector comparing feedback pulses per reference window
module thee_pll_lock_det #(
    parameter int WINDOW     = 64,
    parameter int CNT_W      = 16,
    parameter int TOL        = 2,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fb_pulse,
    input  logic [CNT_W-1:0] exp_count,
    output logic             lock,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             lost_lock
);
    localparam int WIN_W   = $clog2(WINDOW);
    localparam int RUN_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [RUN_W-1:0] LOCK_N   = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] UNLOCK_N = RUN_W'(UNLOCK_CNT);
    localparam logic [CNT_W:0]   TOL_V    = (CNT_W + 1)'(TOL);

    typedef enum logic {ACQ, LOCKED} state_t;

    state_t           state;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] fb_cnt;
    logic [RUN_W-1:0] good_run;
    logic [RUN_W-1:0] bad_run;

    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] total;
    logic [CNT_W:0]   diff;
    logic             good;
    logic             win_end;

    // total doubles as the saturating next value of the feedback counter
    always_comb begin
        sum     = {1'b0, fb_cnt} + (CNT_W + 1)'(fb_pulse);
        total   = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        diff    = (total >= exp_count) ? ({1'b0, total} - {1'b0, exp_count})
                                       : ({1'b0, exp_count} - {1'b0, total});
        good    = (diff <= TOL_V);
        win_end = (win_cnt == WIN_LAST);
    end

    assign lock = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACQ;
            win_cnt    <= '0;
            fb_cnt     <= '0;
            good_run   <= '0;
            bad_run    <= '0;
            meas_count <= '0;
            meas_valid <= 1'b0;
            lost_lock  <= 1'b0;
        end else if (!enable) begin
            state      <= ACQ;
            win_cnt    <= '0;
            fb_cnt     <= '0;
            good_run   <= '0;
            bad_run    <= '0;
            meas_valid <= 1'b0;
            lost_lock  <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            lost_lock  <= 1'b0;
            if (win_end) begin
                win_cnt    <= '0;
                fb_cnt     <= '0;
                meas_count <= total;
                meas_valid <= 1'b1;
                case (state)
                    ACQ: begin
                        if (!good) begin
                            good_run <= '0;
                        end else if (good_run + RUN_W'(1) >= LOCK_N) begin
                            state    <= LOCKED;
                            good_run <= '0;
                            bad_run  <= '0;
                        end else begin
                            good_run <= good_run + RUN_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (good) begin
                            bad_run <= '0;
                        end else if (bad_run + RUN_W'(1) >= UNLOCK_N) begin
                            state     <= ACQ;
                            good_run  <= '0;
                            bad_run   <= '0;
                            lost_lock <= 1'b1;
                        end else begin
                            bad_run <= bad_run + RUN_W'(1);
                        end
                    end
                    default: state <= ACQ;
                endcase
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                fb_cnt  <= total;
            end
        end
    end
endmodule

// File: tb/tb_thee_pll_lock_det.sv
// tb/tb_thee_pll_lock_det.sv - directed and random checks of thee_pll_lock_det against a window-level model
module tb_thee_pll_lock_det;
    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        fb_pulse;
    logic [15:0] exp0;
    logic [3:0]  exp1;
    logic        lock0, lock1, mv0, mv1, ll0, ll1;
    logic [15:0] meas0;
    logic [3:0]  meas1;

    int n_checks = 0;
    int n_pass   = 0;

    thee_pll_lock_det dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fb_pulse(fb_pulse),
        .exp_count(exp0), .lock(lock0), .meas_count(meas0),
        .meas_valid(mv0), .lost_lock(ll0)
    );

    thee_pll_lock_det #(.CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fb_pulse(fb_pulse),
        .exp_count(exp1), .lock(lock1), .meas_count(meas1),
        .meas_valid(mv1), .lost_lock(ll1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: unbounded pulse count per window, saturated only when reported.
    int m_pos, m_cnt;
    int m_meas [2];
    bit m_mv;
    bit m_lock [2];
    bit m_ll   [2];
    int m_good [2];
    int m_bad  [2];
    int tot    [2];
    bit gd     [2];

    function automatic bit is_good(input int t, input int e);
        return (((t > e) ? t - e : e - t) <= 2);
    endfunction

    assign tot[0] = (m_cnt + int'(fb_pulse) > 65535) ? 65535 : m_cnt + int'(fb_pulse);
    assign tot[1] = (m_cnt + int'(fb_pulse) > 15) ? 15 : m_cnt + int'(fb_pulse);
    assign gd[0]  = is_good(tot[0], int'(exp0));
    assign gd[1]  = is_good(tot[1], int'(exp1));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos <= 0;
            m_cnt <= 0;
            m_mv  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_meas[i] <= 0; m_lock[i] <= 1'b0; m_ll[i] <= 1'b0;
                m_good[i] <= 0; m_bad[i]  <= 0;
            end
        end else if (!enable) begin
            m_pos <= 0;
            m_cnt <= 0;
            m_mv  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_lock[i] <= 1'b0; m_ll[i] <= 1'b0;
                m_good[i] <= 0;    m_bad[i] <= 0;
            end
        end else if (m_pos == 63) begin
            m_pos <= 0;
            m_cnt <= 0;
            m_mv  <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_meas[i] <= tot[i];
                m_ll[i]   <= 1'b0;
                if (!m_lock[i]) begin
                    if (!gd[i]) m_good[i] <= 0;
                    else if (m_good[i] + 1 >= 4) begin
                        m_lock[i] <= 1'b1; m_good[i] <= 0; m_bad[i] <= 0;
                    end else m_good[i] <= m_good[i] + 1;
                end else begin
                    if (gd[i]) m_bad[i] <= 0;
                    else if (m_bad[i] + 1 >= 2) begin
                        m_lock[i] <= 1'b0; m_ll[i] <= 1'b1;
                        m_good[i] <= 0;    m_bad[i] <= 0;
                    end else m_bad[i] <= m_bad[i] + 1;
                end
            end
        end else begin
            m_pos <= m_pos + 1;
            m_cnt <= m_cnt + int'(fb_pulse);
            m_mv  <= 1'b0;
            for (int i = 0; i < 2; i++) m_ll[i] <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("lock0", 32'(lock0), 32'(m_lock[0]));
        check("lock1", 32'(lock1), 32'(m_lock[1]));
        check("meas0", 32'(meas0), 32'(m_meas[0]));
        check("meas1", 32'(meas1), 32'(m_meas[1]));
        check("mv0",   32'(mv0),   32'(m_mv));
        check("mv1",   32'(mv1),   32'(m_mv));
        check("ll0",   32'(ll0),   32'(m_ll[0]));
        check("ll1",   32'(ll1),   32'(m_ll[1]));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int pct;
        int e;
        rst_n = 1'b0; enable = 1'b0; fb_pulse = 1'b0; exp0 = '0; exp1 = '0;
        step(3);
        check("rst_lock", 32'(lock0), 0);
        check("rst_meas", 32'(meas0), 0);
        rst_n = 1'b1;
        step(2);

        // acquisition: lock exactly at the 256th edge after enable
        enable = 1'b1; fb_pulse = 1'b1; exp0 = 16'd64; exp1 = 4'd15;
        step(255);
        check("acq_before", 32'(lock0), 0);
        step(1);
        check("acq_lock0", 32'(lock0), 1);
        check("acq_lock1", 32'(lock1), 1);
        check("acq_mv",    32'(mv0), 1);
        check("sat_meas1", 32'(meas1), 15);
        step(64);

        // loss of lock after two empty windows
        fb_pulse = 1'b0;
        step(64);
        check("loss_first", 32'(lock0), 1);
        step(64);
        check("loss_lock", 32'(lock0), 0);
        check("loss_ll",   32'(ll0), 1);
        step(1);
        check("loss_ll_end", 32'(ll0), 0);
        step(63);

        // tolerance edge: 66 locks, 67 is bad
        fb_pulse = 1'b1; exp0 = 16'd66;
        step(256);
        check("tol66", 32'(lock0), 1);
        exp0 = 16'd67;
        step(320);
        check("tol67", 32'(lock0), 0);

        // interrupted acquisition: lock only at the 8th window
        enable = 1'b0; step(1); enable = 1'b1; exp0 = 16'd64;
        for (int w = 0; w < 8; w++) begin
            fb_pulse = (w == 3) ? 1'b0 : 1'b1;
            step(64);
            if (w == 6) check("intr_w7", 32'(lock0), 0);
            if (w == 7) check("intr_w8", 32'(lock0), 1);
        end

        // enable drop while locked: no lost_lock
        enable = 1'b0;
        step(1);
        check("en_lock", 32'(lock0), 0);
        check("en_ll",   32'(ll0), 0);
        enable = 1'b1;
        step(256);
        check("relock", 32'(lock0), 1);

        // async reset without a clock edge
        #3 rst_n = 1'b0;
        #1;
        check("arst_lock", 32'(lock0), 0);
        check("arst_ll",   32'(ll0), 0);
        check("arst_meas", 32'(meas0), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // random windows
        for (int w = 0; w < 30; w++) begin
            pct  = int'($urandom_range(0, 100));
            e    = (64 * pct) / 100 + int'($urandom_range(0, 6)) - 3;
            exp0 = (e < 0) ? 16'd0 : 16'(e);
            exp1 = ($urandom_range(0, 1) == 1) ? 4'd15 : 4'($urandom_range(0, 15));
            for (int c = 0; c < 64; c++) begin
                fb_pulse = (int'($urandom_range(0, 99)) < pct);
                enable   = !(w == 17 && c == 20);
                step(1);
            end
        end
        enable = 1'b1;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/thee_pll_lock_det.md
THEE_PLL_LOCK_DET -- requirements
Module: thee_pll_lock_det

Interface
REQ-001 The block SHALL have parameter WINDOW, default 64: reference-window length in clk cycles, minimum 2.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the feedback counter and of the expected/measured counts.
REQ-003 The block SHALL have parameter TOL, default 2: maximum allowed |measured - expected| for a good window.
REQ-004 The block SHALL have parameter LOCK_CNT, default 4: consecutive good windows needed to declare lock, minimum 1.
REQ-005 The block SHALL have parameter UNLOCK_CNT, default 2: consecutive bad windows needed to drop lock, minimum 1.
REQ-006 The block SHALL have port clk, input, 1 bit: reference clock; the only clock in the block.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have port enable, input, 1 bit: run the detector when high, synchronous clear when low.
REQ-009 The block SHALL have port fb_pulse, input, 1 bit: single-cycle strobe, one per feedback-clock edge, already synchronised to clk.
REQ-010 The block SHALL have port exp_count, input, CNT_W bits: expected fb_pulse count per window, sampled at window end.
REQ-011 The block SHALL have port lock, output, 1 bit: PLL locked indication.
REQ-012 The block SHALL have port meas_count, output, CNT_W bits: fb_pulse count of the last completed window.
REQ-013 The block SHALL have port meas_valid, output, 1 bit: one-cycle pulse when meas_count updates.
REQ-014 The block SHALL have port lost_lock, output, 1 bit: one-cycle pulse when lock falls due to bad windows.

Function
REQ-015 While enable=1, the window counter SHALL count 0..WINDOW-1 and wrap to 0, advancing one step per clk.
REQ-016 The feedback counter SHALL increment on each cycle with fb_pulse=1 and saturate at 2^CNT_W-1 (no wrap).
REQ-017 The window-end cycle SHALL be the cycle with window counter = WINDOW-1. On that cycle, total SHALL equal the feedback count plus fb_pulse, saturated.
REQ-018 At the window-end edge, meas_count SHALL load total, meas_valid SHALL be 1 for the following cycle only, and the feedback counter SHALL restart from 0.
REQ-019 The window SHALL be good iff |total - exp_count| <= TOL, computed in CNT_W+1 bits with no overflow.
REQ-020 The FSM SHALL have two states, ACQ (lock=0) and LOCKED (lock=1), with a good-run counter and a bad-run counter.
REQ-021 In ACQ, a good window SHALL increment good_run; when good_run reaches LOCK_CNT, the FSM SHALL go to LOCKED and clear both run counters.
REQ-022 In ACQ, a bad window SHALL clear good_run.
REQ-023 In LOCKED, a bad window SHALL increment bad_run; when bad_run reaches UNLOCK_CNT, the FSM SHALL go to ACQ, clear both run counters and pulse lost_lock for one cycle.
REQ-024 In LOCKED, a good window SHALL clear bad_run.
REQ-025 State, lock and lost_lock SHALL update at the same window-end edge as meas_count, so lock changes in the same cycle that meas_valid=1.
REQ-026 When enable=0, the next edge SHALL clear the window counter, feedback counter, run counters and meas_valid, and SHALL set state to ACQ with lock=0; no lost_lock pulse is generated; meas_count holds.
REQ-027 On the enable 0->1 transition, the first window SHALL start at window counter 0 on that cycle.
REQ-028 fb_pulse on any cycle SHALL be counted exactly once, in the window that contains that cycle.

Reset
REQ-029 While rst_n=0, all registers SHALL clear immediately regardless of clk: lock=0, meas_count=0, meas_valid=0, lost_lock=0, state=ACQ, all counters=0.
REQ-030 After rst_n rises, operation SHALL resume at the first clk edge with window counter 0; reset mid-window SHALL discard the partial count.

Verification
REQ-031 Lock acquisition: defaults, enable=1, fb_pulse=1 every cycle, exp_count=64 -> meas_valid every 64 cycles with meas_count=64; lock rises with the 4th meas_valid (cycle 256 after enable).
REQ-032 Tolerance: fb_pulse every cycle, exp_count=66 -> lock after 4 windows; exp_count=67 -> lock stays 0 indefinitely.
REQ-033 Loss of lock: once locked, fb_pulse=0 -> meas_count=0 twice, then lock falls with the 2nd bad meas_valid and lost_lock=1 for exactly 1 cycle.
REQ-034 Interrupted acquisition: pattern good, good, good, bad, then good windows -> lock rises only at the 8th window.
REQ-035 Saturation: CNT_W=4, fb_pulse every cycle, WINDOW=64 -> meas_count=15, and exp_count=15 yields lock.
REQ-036 Reset/enable mid-operation: rst_n low while locked -> lock=0 without a clk edge, with no lost_lock pulse; enable low for 1 cycle while locked -> lock=0 and lost_lock stays 0.
